// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage and its neighbours.
// Holds the fetch FSM state type, PC-source selector codes and the
// opcode/funct constants decoded by the control FSM.
package cpu_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_READ = 2'd1,
    FS_WAIT = 2'd2,
    FS_DONE = 2'd3
  } fetch_state_t;

  // PC source selector (orig_pc)
  localparam logic [1:0] ORIG_PC_JUMP   = 2'b00;
  localparam logic [1:0] ORIG_PC_BRANCH = 2'b01;
  localparam logic [1:0] ORIG_PC_ALU    = 2'b10;
  localparam logic [1:0] ORIG_PC_HOLD   = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_BREAK = 6'h0d;

  // Pseudo-direct jump target: the PC already holds PC+4 when this is used.
  function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [31:0] ir);
    return {pc[31:28], ir[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: control-FSM PC-update requests, instruction
// memory read port, and the decoded IR fields handed downstream.
// master = fetch unit side, slave = control FSM / memory / environment side.
interface instr_fetch_unit_if;
  import cpu_pkg::*;

  logic        fetch_req;
  logic        pc_write;
  logic        pc_cond;
  logic        bne_or_beq;
  logic [1:0]  orig_pc;
  logic        alu_zero;
  logic [31:0] branch_target;
  logic [31:0] alu_result;
  logic [31:0] mem_rdata;

  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;
  logic        instr_valid;
  logic        busy;

  modport master (
    input  fetch_req, pc_write, pc_cond, bne_or_beq, orig_pc, alu_zero,
           branch_target, alu_result, mem_rdata,
    output mem_addr, mem_rd, pc, ir, opcode, funct, rs, rt, rd, imm16,
           instr_valid, busy
  );

  modport slave (
    output fetch_req, pc_write, pc_cond, bne_or_beq, orig_pc, alu_zero,
           branch_target, alu_result, mem_rdata,
    input  mem_addr, mem_rd, pc, ir, opcode, funct, rs, rt, rd, imm16,
           instr_valid, busy
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Purpose: owns PC/IR, fetches one instruction per fetch_req, applies control-FSM PC loads.
// Latency: fetch_req in cycle 0 -> instr_valid pulse in cycle MEM_LATENCY+2.
// Backpressure: none; fetch_req/pc_write/pc_cond outside IDLE are dropped, busy flags this.
// Ports: clk, reset (async, active-high); bus_io (master) carries PC-update
// controls, memory read port (mem_addr/mem_rd/mem_rdata) and IR fields.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2,          // 1..15
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus_io
);

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_LATENCY - 1);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [3:0]   cnt_q, cnt_d;

  logic         branch_taken;
  logic         pc_load;
  logic [31:0]  next_pc;

  // beq takes the branch on zero, bne on non-zero
  assign branch_taken = bus_io.pc_cond &
                        (bus_io.bne_or_beq ? bus_io.alu_zero : ~bus_io.alu_zero);
  assign pc_load      = bus_io.pc_write | branch_taken;

  always_comb begin
    next_pc = pc_q;
    case (bus_io.orig_pc)
      ORIG_PC_JUMP:   next_pc = jump_target(pc_q, ir_q);
      ORIG_PC_BRANCH: next_pc = bus_io.branch_target;
      ORIG_PC_ALU:    next_pc = bus_io.alu_result;
      default:        next_pc = pc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      FS_IDLE: begin
        // A PC load and a fetch on the same edge: the READ that follows
        // drives mem_addr from the freshly loaded PC.
        if (pc_load)          pc_d    = next_pc;
        if (bus_io.fetch_req) state_d = FS_READ;
      end
      FS_READ: begin
        cnt_d   = WAIT_LOAD;
        state_d = FS_WAIT;
      end
      FS_WAIT: begin
        if (cnt_q == 4'd0) begin
          ir_d    = bus_io.mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = FS_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      FS_DONE: state_d = FS_IDLE;
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from registered state, so reset removes mem_rd
  // without waiting for a clock edge. pc only moves at the end of WAIT,
  // which keeps mem_addr stable across the whole read.
  assign bus_io.mem_rd      = (state_q == FS_READ) || (state_q == FS_WAIT);
  assign bus_io.mem_addr    = pc_q;
  assign bus_io.instr_valid = (state_q == FS_DONE);
  assign bus_io.busy        = (state_q != FS_IDLE);
  assign bus_io.pc          = pc_q;
  assign bus_io.ir          = ir_q;

  assign bus_io.opcode = ir_q[31:26];
  assign bus_io.rs     = ir_q[25:21];
  assign bus_io.rt     = ir_q[20:16];
  assign bus_io.rd     = ir_q[15:11];
  assign bus_io.funct  = ir_q[5:0];
  assign bus_io.imm16  = ir_q[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two builds (MEM_LATENCY=2 from PC 0, and
// MEM_LATENCY=1 from PC FFFF_FFFC), fixed-latency memory models, and a
// queue-based scoreboard popped on every instr_valid pulse.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_a, reset_b;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t qa[$];
  exp_t qb[$];

  instr_fetch_unit_if ifa ();
  instr_fetch_unit_if ifb ();

  instr_fetch_unit #(.MEM_LATENCY(2), .RESET_PC(32'h0)) dut_a (
    .clk(clk), .reset(reset_a), .bus_io(ifa)
  );
  instr_fetch_unit #(.MEM_LATENCY(1), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .reset(reset_b), .bus_io(ifb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0085_1020;   // add $2,$4,$5
      32'h0000_0004: return 32'h0800_0010;   // j 0x40
      default:       return a ^ 32'hC0DE_0000;
    endcase
  endfunction

  // Memory returns real data only exactly LAT cycles after mem_rd rises.
  int rd_cnt_a, rd_cnt_b;
  always @(posedge clk or posedge reset_a)
    if (reset_a) rd_cnt_a <= 0;
    else rd_cnt_a <= ifa.mem_rd ? rd_cnt_a + 1 : 0;
  always @(posedge clk or posedge reset_b)
    if (reset_b) rd_cnt_b <= 0;
    else rd_cnt_b <= ifb.mem_rd ? rd_cnt_b + 1 : 0;
  assign ifa.mem_rdata = (rd_cnt_a == 2) ? mem_f(ifa.mem_addr) : 32'hBAD0_BAD0;
  assign ifb.mem_rdata = (rd_cnt_b == 1) ? mem_f(ifb.mem_addr) : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (ifa.instr_valid === 1'b1) begin
      if (qa.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL a_unexpected_valid: got instr_valid at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_valid_cycle", 32'(cyc), 32'(e.cyc));
        chk("a_ir", ifa.ir, e.ir);
        chk("a_pc", ifa.pc, e.pc);
        chk("a_opcode", 32'(ifa.opcode), 32'(e.ir[31:26]));
        chk("a_rs", 32'(ifa.rs), 32'(e.ir[25:21]));
        chk("a_rt", 32'(ifa.rt), 32'(e.ir[20:16]));
        chk("a_rd", 32'(ifa.rd), 32'(e.ir[15:11]));
        chk("a_funct", 32'(ifa.funct), 32'(e.ir[5:0]));
        chk("a_imm16", 32'(ifa.imm16), 32'(e.ir[15:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.instr_valid === 1'b1) begin
      if (qb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL b_unexpected_valid: got instr_valid at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_valid_cycle", 32'(cyc), 32'(e.cyc));
        chk("b_ir", ifb.ir, e.ir);
        chk("b_pc", ifb.pc, e.pc);
      end
    end
  end

  task automatic wait_idle_a();
    int k = 0;
    while ((ifa.busy !== 1'b0 || qa.size() != 0) && k < 40) begin tick(); k++; end
    if (k >= 40) begin
      n_vec++; n_err++;
      $display("FAIL a_timeout: busy=%b pending=%0d, expected idle and drained", ifa.busy, qa.size());
      qa.delete();
    end
  endtask

  task automatic wait_idle_b();
    int k = 0;
    while ((ifb.busy !== 1'b0 || qb.size() != 0) && k < 40) begin tick(); k++; end
    if (k >= 40) begin
      n_vec++; n_err++;
      $display("FAIL b_timeout: busy=%b pending=%0d, expected idle and drained", ifb.busy, qb.size());
      qb.delete();
    end
  endtask

  // Issue one fetch on dut_a; any PC-load inputs set by the caller apply on the same edge.
  task automatic fetch_a(input logic [31:0] addr, input logic [31:0] exp_ir, input logic [31:0] exp_pc);
    exp_t e;
    e.ir = exp_ir; e.pc = exp_pc; e.cyc = cyc + 4;
    qa.push_back(e);
    ifa.fetch_req = 1'b1;
    tick();
    ifa.fetch_req = 1'b0;
    ifa.pc_write  = 1'b0;
    ifa.pc_cond   = 1'b0;
    chk("a_read_mem_rd", 32'(ifa.mem_rd), 32'd1);
    chk("a_read_mem_addr", ifa.mem_addr, addr);
    chk("a_read_busy", 32'(ifa.busy), 32'd1);
    wait_idle_a();
  endtask

  task automatic pc_step(input string name, input logic pw, input logic pcc, input logic beq,
                         input logic [1:0] orig, input logic az, input logic [31:0] bt,
                         input logic [31:0] ar, input logic [31:0] exp_pc);
    ifa.pc_write = pw; ifa.pc_cond = pcc; ifa.bne_or_beq = beq; ifa.orig_pc = orig;
    ifa.alu_zero = az; ifa.branch_target = bt; ifa.alu_result = ar;
    tick();
    ifa.pc_write = 1'b0; ifa.pc_cond = 1'b0;
    chk(name, ifa.pc, exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    ifa.fetch_req = 0; ifa.pc_write = 0; ifa.pc_cond = 0; ifa.bne_or_beq = 0;
    ifa.orig_pc = ORIG_PC_HOLD; ifa.alu_zero = 0; ifa.branch_target = 0; ifa.alu_result = 0;
    ifb.fetch_req = 0; ifb.pc_write = 0; ifb.pc_cond = 0; ifb.bne_or_beq = 0;
    ifb.orig_pc = ORIG_PC_HOLD; ifb.alu_zero = 0; ifb.branch_target = 0; ifb.alu_result = 0;
    tick(); tick();
    chk("rst_pc", ifa.pc, 32'h0);
    chk("rst_ir", ifa.ir, 32'h0);
    chk("rst_mem_rd", 32'(ifa.mem_rd), 32'd0);
    chk("rst_valid", 32'(ifa.instr_valid), 32'd0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_b_pc", ifb.pc, 32'hFFFF_FFFC);
    reset_a = 1'b0; reset_b = 1'b0;
    tick();

    // 1: first fetch from address 0
    fetch_a(32'h0, 32'h0085_1020, 32'h4);
    chk("t1_opcode", 32'(ifa.opcode), 32'h0);
    chk("t1_funct", 32'(ifa.funct), 32'h20);
    chk("t1_rs", 32'(ifa.rs), 32'd4);
    chk("t1_rt", 32'(ifa.rt), 32'd5);
    chk("t1_rd", 32'(ifa.rd), 32'd2);

    // 2: fetch the jump, then apply it
    fetch_a(32'h4, 32'h0800_0010, 32'h8);
    pc_step("t2_jump", 1, 0, 0, ORIG_PC_JUMP, 0, 32'h0, 32'h0, 32'h0000_0040);

    // 3: conditional branches and other sources
    pc_step("t3_beq_taken",   0, 1, 1, ORIG_PC_BRANCH, 1, 32'h20, 32'h0, 32'h20);
    pc_step("t3_beq_nottaken",0, 1, 1, ORIG_PC_BRANCH, 0, 32'h80, 32'h0, 32'h20);
    pc_step("t3_bne_nottaken",0, 1, 0, ORIG_PC_BRANCH, 1, 32'h80, 32'h0, 32'h20);
    pc_step("t3_bne_taken",   0, 1, 0, ORIG_PC_BRANCH, 0, 32'h60, 32'h0, 32'h60);
    pc_step("t3_alu_src",     1, 0, 0, ORIG_PC_ALU,    0, 32'h0, 32'h100, 32'h100);
    pc_step("t3_hold_src",    1, 0, 0, ORIG_PC_HOLD,   0, 32'h0, 32'h300, 32'h100);
    pc_step("t3_no_load",     0, 0, 0, ORIG_PC_BRANCH, 0, 32'h500, 32'h0, 32'h100);

    // 4: requests held through READ/WAIT are ignored
    begin
      exp_t e;
      e.ir = 32'hC0DE_0100; e.pc = 32'h104; e.cyc = cyc + 4;
      qa.push_back(e);
      ifa.fetch_req = 1'b1;
      tick();
      ifa.pc_write = 1'b1; ifa.orig_pc = ORIG_PC_ALU; ifa.alu_result = 32'hBEEF_0000;
      tick(); tick();
      chk("t4_pc_in_wait", ifa.pc, 32'h100);
      chk("t4_addr_in_wait", ifa.mem_addr, 32'h100);
      tick();
      ifa.fetch_req = 1'b0; ifa.pc_write = 1'b0;
      wait_idle_a();
      repeat (6) tick();
      chk("t4_pc_after", ifa.pc, 32'h104);
      chk("t4_no_refetch", 32'(ifa.busy), 32'd0);
    end

    // Load and fetch on the same edge: the fetch reads the new PC
    ifa.pc_write = 1'b1; ifa.orig_pc = ORIG_PC_BRANCH; ifa.branch_target = 32'h200;
    fetch_a(32'h200, 32'hC0DE_0200, 32'h204);

    // 5: reset during WAIT aborts the fetch
    ifa.fetch_req = 1'b1;
    tick();
    ifa.fetch_req = 1'b0;
    tick();
    reset_a = 1'b1;
    #1;
    chk("t5_mem_rd", 32'(ifa.mem_rd), 32'd0);
    chk("t5_pc", ifa.pc, 32'h0);
    chk("t5_busy", 32'(ifa.busy), 32'd0);
    tick();
    reset_a = 1'b0;
    repeat (6) tick();
    chk("t5_ir", ifa.ir, 32'h0);
    fetch_a(32'h0, 32'h0085_1020, 32'h4);

    // 6: one-cycle memory, PC wraps past the top of the address space
    begin
      exp_t e;
      e.ir = mem_f(32'hFFFF_FFFC); e.pc = 32'h0; e.cyc = cyc + 3;
      qb.push_back(e);
      ifb.fetch_req = 1'b1;
      tick();
      ifb.fetch_req = 1'b0;
      chk("t6_addr", ifb.mem_addr, 32'hFFFF_FFFC);
      wait_idle_b();
      chk("t6_pc_wrap", ifb.pc, 32'h0);
      e.ir = 32'h0085_1020; e.pc = 32'h4; e.cyc = cyc + 3;
      qb.push_back(e);
      ifb.fetch_req = 1'b1;
      tick();
      ifb.fetch_req = 1'b0;
      wait_idle_b();
    end

    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
